// File: rtl/dot_product_pkg.sv
// Shared sizing and bit-manipulation helpers for the streaming dot-product datapath.
// Helpers work on fixed maximum widths; callers size-cast their arguments and results.
package dot_product_pkg;

   localparam int MAX_DW  = 32;
   localparam int MAX_BUS = 1024;
   localparam int MAX_OW  = 128;

   function automatic int calc_ow(input int dw, input int n_bit, input int beat_bit);
      return 2*dw + n_bit + beat_bit;
   endfunction

   // Lane i occupies bits [(i+1)*dw-1 : i*dw] of the packed operand bus
   function automatic logic [MAX_DW-1:0] lane_slice(input logic [MAX_BUS-1:0] bus,
                                                    input int lane, input int dw);
      logic [MAX_DW-1:0] mask;
      mask = ~({MAX_DW{1'b1}} << dw);
      return MAX_DW'(bus >> (lane*dw)) & mask;
   endfunction

   // Extends the low w bits of v, replicating bit w-1 when sgn is set
   function automatic logic [MAX_OW-1:0] extend(input logic [MAX_OW-1:0] v,
                                                input int w, input logic sgn);
      logic [MAX_OW-1:0] fill;
      fill = {MAX_OW{1'b1}} << w;
      if (sgn && (((v >> (w-1)) & MAX_OW'(1)) != '0))
         return v | fill;
      else
         return v & ~fill;
   endfunction

endpackage

// File: rtl/dot_lane_mul.sv
// One lane: registered DW x DW multiply (signed or unsigned), product extended to OW.
module dot_lane_mul
   import dot_product_pkg::*;
#(
   parameter int DW = 8,
   parameter int OW = 23
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ld,
   input  logic          mode,
   input  logic          ext_mode,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [OW-1:0] prod_ext
);

   localparam int PW = 2*DW;

   logic [PW-1:0] a_ext;
   logic [PW-1:0] b_ext;
   logic [PW-1:0] prod_next;
   logic [PW-1:0] prod_reg;

   // Low 2*DW bits of the widened product are exact for both signed and unsigned operands
   assign a_ext     = PW'(extend(MAX_OW'(a), DW, mode));
   assign b_ext     = PW'(extend(MAX_OW'(b), DW, mode));
   assign prod_next = a_ext * b_ext;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prod_reg <= '0;
      end else if (ld) begin
         prod_reg <= prod_next;
      end
   end

   assign prod_ext = OW'(extend(MAX_OW'(prod_reg), PW, ext_mode));

endmodule

// File: rtl/dot_product_stream.sv
// Streaming multi-beat dot product: lane multiply stage, adder tree + accumulator,
// and a result register behind a valid/ready output.
module dot_product_stream
   import dot_product_pkg::*;
#(
   parameter int  N        = 8,
   parameter int  N_bit    = 3,
   parameter int  DW       = 8,
   parameter int  BEAT_BIT = 4,
   localparam int OW       = calc_ow(DW, N_bit, BEAT_BIT)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_last,
   input  logic            signed_mode,
   input  logic [DW*N-1:0] inp1,
   input  logic [DW*N-1:0] inp2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [OW-1:0]   outp,
   output logic            out_err
);

   logic                en;
   logic                accept;
   logic                first_beat;
   logic                beat_mode;
   logic                cnt_full;
   logic                eff_last;
   logic                beat_err;

   logic [BEAT_BIT-1:0] cnt_reg;
   logic                mode_reg;

   logic                s1_valid_reg;
   logic                s1_last_reg;
   logic                s1_err_reg;
   logic                s1_mode_reg;

   logic [OW-1:0]       lane_ext [N];
   logic [OW-1:0]       sum;
   logic [OW-1:0]       acc_reg;
   logic [OW-1:0]       outp_reg;
   logic                out_valid_reg;
   logic                out_err_reg;

   // The whole pipeline advances together; a held result stalls everything upstream
   assign en         = !out_valid_reg || out_ready;
   assign in_ready   = en;
   assign accept     = in_valid && en;
   assign first_beat = (cnt_reg == '0);
   assign beat_mode  = first_beat ? signed_mode : mode_reg;
   assign cnt_full   = &cnt_reg;
   assign eff_last   = in_last || cnt_full;
   assign beat_err   = cnt_full && !in_last;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_lane
         logic [DW-1:0] a;
         logic [DW-1:0] b;

         assign a = DW'(lane_slice(MAX_BUS'(inp1), gi, DW));
         assign b = DW'(lane_slice(MAX_BUS'(inp2), gi, DW));

         dot_lane_mul #(
            .DW (DW),
            .OW (OW)
         ) u_mul (
            .clk      (clk),
            .rst_n    (rst_n),
            .ld       (accept),
            .mode     (beat_mode),
            .ext_mode (s1_mode_reg),
            .a        (a),
            .b        (b),
            .prod_ext (lane_ext[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_reg  <= '0;
         mode_reg <= 1'b0;
      end else if (accept) begin
         cnt_reg <= eff_last ? '0 : cnt_reg + 1'b1;
         if (first_beat) begin
            mode_reg <= signed_mode;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_last_reg  <= 1'b0;
         s1_err_reg   <= 1'b0;
         s1_mode_reg  <= 1'b0;
      end else if (en) begin
         s1_valid_reg <= in_valid;
         s1_last_reg  <= eff_last;
         s1_err_reg   <= beat_err;
         s1_mode_reg  <= beat_mode;
      end
   end

   always_comb begin
      sum = '0;
      for (int i = 0; i < N; i++) begin
         sum = sum + lane_ext[i];
      end
   end

   // With en high any held result is being retired, so out_valid simply follows completion
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_reg       <= '0;
         outp_reg      <= '0;
         out_err_reg   <= 1'b0;
         out_valid_reg <= 1'b0;
      end else if (en) begin
         out_valid_reg <= s1_valid_reg && s1_last_reg;
         if (s1_valid_reg) begin
            if (s1_last_reg) begin
               outp_reg    <= acc_reg + sum;
               out_err_reg <= s1_err_reg;
               acc_reg     <= '0;
            end else begin
               acc_reg <= acc_reg + sum;
            end
         end
      end
   end

   assign outp      = outp_reg;
   assign out_err   = out_err_reg;
   assign out_valid = out_valid_reg;

endmodule

// File: doc/dot_product_stream.md
# dot_product_stream

Pipelined, streaming successor to the combinational dot-product block. It accepts N-lane operand beats through a valid/ready handshake and accumulates lane products across a multi-beat vector of up to 2**BEAT_BIT beats. It supports runtime signed or unsigned arithmetic and presents one registered result per vector through a valid/ready output. It sits between the operand-fetch logic and the result FIFO in the row-by-column compute path.

## Interface
- N, 8: lanes per beat
- N_bit, 3: log2(N), the lane-sum growth bits
- DW, 8: bits per operand element
- BEAT_BIT, 4: log2 of max beats per vector (MAX_BEATS = 2**BEAT_BIT)
- Derived OW = 2*DW + N_bit + BEAT_BIT (23 at defaults), the result width

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts a beat this cycle
- in_last  in  1  final beat of the current vector
- signed_mode  in  1  1 = two's-complement operands; sampled on the first beat of a vector
- inp1  in  DW*N  lane i occupies bits [(i+1)*DW-1 : i*DW]
- inp2  in  DW*N  same packing as inp1
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts the result
- outp  out  OW  dot product of the whole vector, sign- or zero-extended per mode
- out_err  out  1  vector was force-terminated at MAX_BEATS without in_last

## Operation
- Global advance enable: en = !out_valid || out_ready. in_ready = en, driven combinationally.
- Accept: in_valid && in_ready at an edge.
- Stage S1, registered on accept when en:
  - N lane products, each 2*DW bits
  - the beat's last flag and err flag
  - the vector mode
  - S1 valid bit
- Mode: latched when the beat counter is 0 (first beat). All later beats of the vector use the latched mode; mid-vector changes to signed_mode are ignored. A single-beat vector uses that beat's signed_mode.
- Beat counter (BEAT_BIT bits):
  - Increments on each accept.
  - Clears on an accepted last beat.
  - Effective last = in_last || (cnt == MAX_BEATS-1). err = that condition && !in_last.
- Stage S2 / accumulator, when en and S1 valid:
  - sum = the N products extended to OW (signed if mode, else zero).
  - Non-last beat: acc <= acc + sum.
  - Last beat: outp <= acc + sum, out_err <= err, out_valid <= 1, acc <= 0.
- Output handshake: out_valid && out_ready retires the result. out_valid drops unless a new last beat completes in the same edge. outp and out_err hold stable while out_valid && !out_ready.
- Stall: when en = 0, S1, acc, the counter and the mode are all frozen.
- Arithmetic:
  - Modulo 2**OW.
  - No overflow is possible within MAX_BEATS beats at any parameterisation.

## Timing
- Reset (rst_n = 0 at an edge):
  - out_valid = 0, outp = 0, out_err = 0
  - acc = 0, counter = 0, S1 valid = 0, mode = 0
  - in_ready = 1 on the following cycle
- Reset mid-vector discards all partial state. The next accepted beat is a first beat.
- Latency: a last beat accepted at edge E0 gives out_valid = 1 after E1, provided en stays 1.
- Throughput: one beat per cycle.
- Back-to-back vectors:
  - A first beat may follow a last beat with no bubble; acc restarts from 0.
  - With out_ready held at 1, one result per vector is produced, with no dead cycles.
- Simultaneous retire and complete: when out_ready = 1 and a new last beat sits in S1 at the same edge, the new result replaces the old one and out_valid stays 1.

## Structure
- Package dot_product_pkg holds:
  - a function computing OW from DW, N_bit and BEAT_BIT
  - a function for lane slice extraction
  - a sign/zero extension helper
- Sub-module dot_lane_mul: one lane's registered DW x DW multiply with mode-controlled extension to OW. Instantiated N times in a generate loop.
- Top level holds the counter, the mode latch, the adder tree plus accumulator, and the output register.

## Test plan
- Unsigned single beat: mode 0, all lanes 0xFF x 0xFF, in_last = 1 → outp = 520200, out_err = 0, two cycles after accept.
- Signed single beat: mode 1, all lanes 0x80 x 0x7F → outp = -130048 as 23-bit two's complement (0x7E0400).
- Multi-beat with mode latch:
  - Three beats of all-ones, last on beat 3 → outp = 24.
  - Repeat with signed_mode toggled on beat 2 → identical result.
- Backpressure: hold out_ready = 0 with two vectors queued.
  - in_ready drops, outp is held stable, no beat is lost.
  - Releasing out_ready yields both results in order.
- Forced termination: 16 beats of ones with in_last never set → outp = 128 and out_err = 1. The 17th beat starts a fresh vector.
- Reset mid-vector: assert rst_n = 0 after 2 of 4 beats, then send a fresh one-beat vector of ones → outp = 8, with no residue from before the reset.
